// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the gated clock divider.
package clkdiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam int MIN_RATIO     = 2;
  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/clkdiv_period_counter.sv
// Period counter for the gated clock divider: clamps the loaded ratio to at
// least MIN_RATIO, counts 0..R-1 while running and flags the wrap cycle.
module clkdiv_period_counter
  import clkdiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [WIDTH-1:0] ratio,
  output logic [WIDTH-1:0] eff_ratio,
  output logic [WIDTH-1:0] cnt_next,
  output logic             wrap
);

  logic [WIDTH-1:0] cnt;

  assign eff_ratio = (ratio < WIDTH'(MIN_RATIO)) ? WIDTH'(MIN_RATIO) : ratio;
  assign wrap      = (cnt == eff_ratio - WIDTH'(1));

  // Idle holds the counter at zero so the first running edge starts a period.
  assign cnt_next  = (run && !wrap) ? cnt + WIDTH'(1) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/clkdiv_gate_ctrl.sv
// Gated, glitch-free clock divider with ratio reload handshake.
// Define CLKDIV_DUTY50_EN to add falling-edge duty correction for odd ratios.
module clkdiv_gate_ctrl
  import clkdiv_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DIV_RESET = 2
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             EN,
  input  logic             CFG_REQ,
  input  logic [WIDTH-1:0] CFG_DIV,
  output logic             CFG_ACK,
  output logic             CLKOUT,
  output logic             RUNNING
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] ratio;
  logic [WIDTH-1:0] eff_ratio;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] high_cnt;
  logic             wrap;
  logic             run;
  logic             load;
  logic             clkout_q;
  logic             clkout_d;

  assign run      = (state != IDLE);
  assign high_cnt = eff_ratio >> 1;

  // A ratio change only lands at a period boundary so no pulse is cut short.
  assign load = CFG_REQ && !CFG_ACK && ((state == IDLE) || wrap);

  clkdiv_period_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk      (CLK),
    .rst_n    (RN),
    .run      (run),
    .ratio    (ratio),
    .eff_ratio(eff_ratio),
    .cnt_next (cnt_next),
    .wrap     (wrap)
  );

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = EN ? RUN : IDLE;
      RUN:     state_next = EN ? RUN : DRAIN;
      DRAIN:   state_next = EN ? RUN : (wrap ? IDLE : DRAIN);
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    RUNNING  = (state == RUN) || (state == DRAIN);
    clkout_d = (state_next != IDLE) && (cnt_next < high_cnt);
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      clkout_q <= 1'b0;
      CFG_ACK  <= 1'b0;
      ratio    <= WIDTH'(DIV_RESET);
    end else begin
      clkout_q <= clkout_d;
      CFG_ACK  <= load;
      if (load) begin
        ratio <= CFG_DIV;
      end
    end
  end

`ifdef CLKDIV_DUTY50_EN
  logic ext_q;

  // Holds the output high half a period past the registered fall for odd R.
  always_ff @(negedge CLK or negedge RN) begin
    if (!RN) begin
      ext_q <= 1'b0;
    end else begin
      ext_q <= clkout_q & eff_ratio[0];
    end
  end

  assign CLKOUT = clkout_q | ext_q;
`else
  assign CLKOUT = clkout_q;
`endif

endmodule

// File: tb/tb_clkdiv_gate_ctrl.sv
// Directed self-checking bench for clkdiv_gate_ctrl (default build, WIDTH=8, DIV_RESET=2).
module tb_clkdiv_gate_ctrl;

  logic       CLK;
  logic       RN;
  logic       EN;
  logic       CFG_REQ;
  logic [7:0] CFG_DIV;
  logic       CFG_ACK;
  logic       CLKOUT;
  logic       RUNNING;

  int checks = 0;
  int errors = 0;

  clkdiv_gate_ctrl #(
    .WIDTH    (8),
    .DIV_RESET(2)
  ) dut (
    .CLK    (CLK),
    .RN     (RN),
    .EN     (EN),
    .CFG_REQ(CFG_REQ),
    .CFG_DIV(CFG_DIV),
    .CFG_ACK(CFG_ACK),
    .CLKOUT (CLKOUT),
    .RUNNING(RUNNING)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drives one set of inputs across a rising edge, then checks all outputs.
  task automatic applyStimulus(input string tag, input logic en, input logic req,
                               input logic [7:0] div, input logic exp_clk,
                               input logic exp_run, input logic exp_ack);
    EN      = en;
    CFG_REQ = req;
    CFG_DIV = div;
    @(posedge CLK);
    #1;
    checkOutput({tag, ".clkout"},  {31'd0, CLKOUT},  {31'd0, exp_clk});
    checkOutput({tag, ".running"}, {31'd0, RUNNING}, {31'd0, exp_run});
    checkOutput({tag, ".ack"},     {31'd0, CFG_ACK}, {31'd0, exp_ack});
  endtask

  initial begin
    RN      = 1'b0;
    EN      = 1'b0;
    CFG_REQ = 1'b0;
    CFG_DIV = 8'd0;
    #2;
    checkOutput("rst.clkout",  {31'd0, CLKOUT},  32'd0);
    checkOutput("rst.running", {31'd0, RUNNING}, 32'd0);
    checkOutput("rst.ack",     {31'd0, CFG_ACK}, 32'd0);
    @(posedge CLK);
    #1;
    RN = 1'b1;

    // Reset ratio 2: output toggles every edge, then drain back to idle.
    for (int i = 0; i < 5; i++) applyStimulus("r2_run", 1, 0, 8'd0, (i % 2) == 0, 1, 0);
    applyStimulus("r2_drain", 0, 0, 8'd0, 0, 1, 0);
    applyStimulus("r2_idle",  0, 0, 8'd0, 0, 0, 0);

    // Idle load of 5 with a held request: one ignored cycle after each ack.
    applyStimulus("cfg_ld1",  0, 1, 8'd5, 0, 0, 1);
    applyStimulus("cfg_ign",  0, 1, 8'd5, 0, 0, 0);
    applyStimulus("cfg_ld2",  0, 1, 8'd5, 0, 0, 1);
    applyStimulus("cfg_rel",  0, 0, 8'd5, 0, 0, 0);

    // Ratio 5: 2 high / 3 low, then drain from cnt=0 completes the period.
    for (int i = 0; i < 11; i++) applyStimulus("r5_run", 1, 0, 8'd5, (i % 5) < 2, 1, 0);
    applyStimulus("r5_drain", 0, 0, 8'd5, 1, 1, 0);
    applyStimulus("r5_drain", 0, 0, 8'd5, 0, 1, 0);
    applyStimulus("r5_drain", 0, 0, 8'd5, 0, 1, 0);
    applyStimulus("r5_drain", 0, 0, 8'd5, 0, 1, 0);
    applyStimulus("r5_idle",  0, 0, 8'd5, 0, 0, 0);

    // Load 4 together with EN, then request 6 at cnt=1; it lands at the wrap.
    applyStimulus("r4_start", 1, 1, 8'd4, 1, 1, 1);
    applyStimulus("r4_c1",    1, 0, 8'd4, 1, 1, 0);
    applyStimulus("r4_req_c2", 1, 1, 8'd6, 0, 1, 0);
    applyStimulus("r4_req_c3", 1, 1, 8'd6, 0, 1, 0);
    applyStimulus("r4_wrap",  1, 1, 8'd6, 1, 1, 1);
    for (int j = 1; j <= 6; j++) applyStimulus("r6_run", 1, 0, 8'd6, (j % 6) < 3, 1, 0);

    // Ratio 6, EN low at cnt=2: finish the period, then idle.
    applyStimulus("r6_c1",    1, 0, 8'd6, 1, 1, 0);
    applyStimulus("r6_c2",    1, 0, 8'd6, 1, 1, 0);
    applyStimulus("r6_dr_c3", 0, 0, 8'd6, 0, 1, 0);
    applyStimulus("r6_dr_c4", 0, 0, 8'd6, 0, 1, 0);
    applyStimulus("r6_dr_c5", 0, 0, 8'd6, 0, 1, 0);
    applyStimulus("r6_idle",  0, 0, 8'd6, 0, 0, 0);

    // Restart, cancelled request, drain then EN back high at cnt=4.
    applyStimulus("r6b_c0",   1, 0, 8'd6, 1, 1, 0);
    applyStimulus("r6b_c1",   1, 1, 8'd2, 1, 1, 0);
    applyStimulus("r6b_c2",   1, 0, 8'd2, 1, 1, 0);
    applyStimulus("r6b_c3",   0, 0, 8'd2, 0, 1, 0);
    applyStimulus("r6b_c4",   0, 0, 8'd2, 0, 1, 0);
    applyStimulus("r6b_c5",   1, 0, 8'd2, 0, 1, 0);
    applyStimulus("r6b_c0b",  1, 0, 8'd2, 1, 1, 0);
    applyStimulus("r6b_c1b",  1, 0, 8'd2, 1, 1, 0);
    applyStimulus("r6b_c2b",  1, 0, 8'd2, 1, 1, 0);
    applyStimulus("r6b_c3b",  1, 0, 8'd2, 0, 1, 0);

    // Move to ratio 8, reach cnt=3, then reset with a request pending.
    applyStimulus("r8_req_c4", 1, 1, 8'd8, 0, 1, 0);
    applyStimulus("r8_req_c5", 1, 1, 8'd8, 0, 1, 0);
    applyStimulus("r8_wrap",  1, 1, 8'd8, 1, 1, 1);
    applyStimulus("r8_c1",    1, 0, 8'd8, 1, 1, 0);
    applyStimulus("r8_c2",    1, 0, 8'd8, 1, 1, 0);
    applyStimulus("r8_c3",    1, 0, 8'd8, 1, 1, 0);
    CFG_REQ = 1'b1;
    CFG_DIV = 8'd3;
    #2;
    RN = 1'b0;
    #1;
    checkOutput("mid_rst.clkout",  {31'd0, CLKOUT},  32'd0);
    checkOutput("mid_rst.running", {31'd0, RUNNING}, 32'd0);
    checkOutput("mid_rst.ack",     {31'd0, CFG_ACK}, 32'd0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    checkOutput("held_rst.ack",    {31'd0, CFG_ACK}, 32'd0);
    checkOutput("held_rst.clkout", {31'd0, CLKOUT},  32'd0);
    CFG_REQ = 1'b0;
    EN      = 1'b0;
    RN      = 1'b1;

    // Ratio is back to DIV_RESET=2 after release.
    applyStimulus("post_rst", 1, 0, 8'd0, 1, 1, 0);
    applyStimulus("post_rst", 1, 0, 8'd0, 0, 1, 0);
    applyStimulus("post_rst", 1, 0, 8'd0, 1, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clkdiv_gate_ctrl.md
CLKDIV_GATE_CTRL -- requirements
Module: clkdiv_gate_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of divide ratio and period counter.
REQ-002 SHALL have parameter DIV_RESET, default 2, divide ratio loaded at reset.
REQ-003 SHALL have port CLK  input  1  sole clock; source clock for the divided output.
REQ-004 SHALL have port RN  input  1  asynchronous active-low reset.
REQ-005 SHALL have port EN  input  1  level request to run the divided clock.
REQ-006 SHALL have port CFG_REQ  input  1  level request to load a new ratio.
REQ-007 SHALL have port CFG_DIV  input  WIDTH  requested ratio; stable while CFG_REQ is high.
REQ-008 SHALL have port CFG_ACK  output  1  one-cycle pulse: CFG_DIV has been loaded.
REQ-009 SHALL have port CLKOUT  output  1  registered, glitch-free divided clock driving the downstream clock inverter tree.
REQ-010 SHALL have port RUNNING  output  1  high in states RUN and DRAIN.

Function
REQ-011 Effective ratio R SHALL be max(loaded ratio, 2); loaded values 0 and 1 divide by 2.
REQ-012 High count H SHALL be floor(R/2); CLKOUT high for H CLK periods, low for R-H periods.
REQ-013 States SHALL be IDLE, RUN, DRAIN; period counter cnt runs 0..R-1 and wraps to 0.
REQ-014 IDLE: cnt=0, CLKOUT=0; EN sampled high -> RUN on the same edge, CLKOUT=1 on that edge (cnt_next=0).
REQ-015 RUN/DRAIN: each edge cnt advances; CLKOUT register SHALL take (cnt_next < H).
REQ-016 RUN with EN low -> DRAIN; no truncation of the current period.
REQ-017 DRAIN with EN high -> RUN, no gap or glitch in CLKOUT.
REQ-018 DRAIN at wrap (cnt=R-1) with EN low -> IDLE, CLKOUT=0; EN high at wrap -> RUN.
REQ-019 CFG_REQ SHALL be accepted only when CFG_ACK is low (one-cycle ignore after each ACK).
REQ-020 Accepted CFG_REQ in IDLE SHALL load on the next edge, CFG_ACK high the following cycle.
REQ-021 Accepted CFG_REQ in RUN/DRAIN SHALL load only at a wrap edge; CFG_ACK high for the cycle after that edge; new R applies from cnt=0.
REQ-022 CFG_REQ and EN rising together in IDLE: ratio loads on that edge, first period uses new R.
REQ-023 CFG_REQ deasserted before ACK SHALL cancel the request; no load, no ACK.
REQ-024 CLKOUT SHALL never produce a high or low pulse shorter than one CLK period (R>=2).

Reset
REQ-025 RN low SHALL asynchronously force IDLE, cnt=0, ratio=DIV_RESET, CLKOUT=0, CFG_ACK=0, RUNNING=0.
REQ-026 Reset mid-period SHALL drop CLKOUT immediately; pending request discarded; after release, EN restarts per REQ-014.

Configuration
REQ-027 Macro CLKDIV_DUTY50_EN SHALL select odd-ratio duty correction.
REQ-028 With CLKDIV_DUTY50_EN: for odd R, a falling-edge CLK flop SHALL extend CLKOUT high by half a period (high H+0.5, low R-H-0.5 periods); even R unchanged; falling-edge flop also reset by RN.
REQ-029 Without CLKDIV_DUTY50_EN: no falling-edge logic; behaviour exactly REQ-012.

Structure
REQ-030 Package clkdiv_pkg SHALL hold the state enum (IDLE, RUN, DRAIN), MIN_RATIO=2, default WIDTH.
REQ-031 Sub-module clkdiv_period_counter SHALL hold cnt, wrap detect and R clamp; FSM, handshake, CLKOUT stay in clkdiv_gate_ctrl.

Verification
REQ-032 Reset, DIV_RESET=2, EN=1 -> CLKOUT toggles every CLK edge (1,0,1,0), RUNNING=1 one edge after EN.
REQ-033 Load CFG_DIV=5 in IDLE, EN=1 -> CLKOUT 2 high/3 low; with CLKDIV_DUTY50_EN 2.5 high/2.5 low.
REQ-034 Running R=4, CFG_REQ with CFG_DIV=6 at cnt=1 -> ACK the cycle after the cnt=3 wrap, next period 3 high/3 low.
REQ-035 Running R=6, EN low at cnt=2 -> DRAIN, CLKOUT completes period, IDLE after wrap, CLKOUT=0, RUNNING=0.
REQ-036 DRAIN with R=6, EN back high at cnt=4 -> continuous periods, no short pulse.
REQ-037 RN low at cnt=3 of R=8 with CFG_REQ pending -> all outputs 0 immediately, ratio=DIV_RESET, no ACK.
